// File: rtl/bank_burst_ctrl.sv
// -----------------------------------------------------------------------------
// bank_burst_ctrl
// Burst initiator for one Bank model. Accepts a single read or write request
// over a valid/ready handshake and turns it into BL consecutive column
// accesses on the Bank's row/column/rd_o_wr/dq port. Read beats returned by
// the Bank (one cycle after the address) are packed into one wide response.
//
// Ports:
//   clk, rst              single clock, synchronous active-high reset
//   req_valid/req_ready   request handshake
//   req_wr                1 = write burst, 0 = read burst
//   req_row, req_col      target row and starting column
//   req_wdata             write data, beat k at [k*DEVICE_WIDTH +: DEVICE_WIDTH]
//   rsp_valid             one-cycle completion pulse
//   rsp_wr                kind of the completed transaction
//   rsp_rdata             read data, packed like req_wdata
//   bank_rd_o_wr          0 = read, 1 = write
//   bank_dqin/bank_dqout  Bank write / read data
//   bank_row/bank_column  Bank address
// -----------------------------------------------------------------------------
module bank_burst_ctrl #(
    parameter int DEVICE_WIDTH = 4,
    parameter int COLWIDTH     = 10,
    parameter int CHWIDTH      = 5,
    parameter int BL           = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_wr,
    input  logic [CHWIDTH-1:0]         req_row,
    input  logic [COLWIDTH-1:0]        req_col,
    input  logic [DEVICE_WIDTH*BL-1:0] req_wdata,
    output logic                       rsp_valid,
    output logic                       rsp_wr,
    output logic [DEVICE_WIDTH*BL-1:0] rsp_rdata,
    output logic                       bank_rd_o_wr,
    output logic [DEVICE_WIDTH-1:0]    bank_dqin,
    input  logic [DEVICE_WIDTH-1:0]    bank_dqout,
    output logic [CHWIDTH-1:0]         bank_row,
    output logic [COLWIDTH-1:0]        bank_column
);

    localparam int CNTW = (BL > 1) ? $clog2(BL) : 1;
    localparam int DW   = DEVICE_WIDTH * BL;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t                  state_r, state_s;
    logic [CNTW-1:0]         beat_r, beat_s;     // beat currently on the Bank port
    logic                    wr_r, wr_s;
    logic [DW-1:0]           wdata_r, wdata_s;
    // rd_pend_r: bank_dqout in this cycle carries read beat rd_idx_r
    logic                    rd_pend_r, rd_pend_s;
    logic [CNTW-1:0]         rd_idx_r, rd_idx_s;

    logic                    ready_s;
    logic                    rsp_valid_s;
    logic                    rsp_wr_s;
    logic [DW-1:0]           rdata_s;
    logic                    rd_o_wr_s;
    logic [DEVICE_WIDTH-1:0] dqin_s;
    logic [CHWIDTH-1:0]      row_s;
    logic [COLWIDTH-1:0]     col_s;

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_s     = state_r;
        beat_s      = beat_r;
        wr_s        = wr_r;
        wdata_s     = wdata_r;
        rd_pend_s   = (state_r == BURST) && !wr_r;
        rd_idx_s    = beat_r;
        ready_s     = 1'b0;
        rsp_valid_s = 1'b0;
        rsp_wr_s    = rsp_wr;
        rdata_s     = rsp_rdata;
        rd_o_wr_s   = 1'b0;
        dqin_s      = '0;
        row_s       = bank_row;
        col_s       = bank_column;

        // Bank data lags the address by one cycle, so capture uses the
        // beat index remembered from the previous cycle.
        if (rd_pend_r) begin
            rdata_s[int'(rd_idx_r) * DEVICE_WIDTH +: DEVICE_WIDTH] = bank_dqout;
        end else begin
            rdata_s = rsp_rdata;
        end

        case (state_r)
            IDLE: begin
                if (req_valid && req_ready) begin
                    state_s   = BURST;
                    beat_s    = '0;
                    wr_s      = req_wr;
                    wdata_s   = req_wdata;
                    row_s     = req_row;
                    col_s     = req_col;
                    rd_o_wr_s = req_wr;
                    if (req_wr) begin
                        dqin_s = req_wdata[DEVICE_WIDTH-1:0];
                    end else begin
                        dqin_s = '0;
                    end
                end else begin
                    ready_s = 1'b1;
                end
            end
            BURST: begin
                if (beat_r == CNTW'(BL - 1)) begin
                    state_s = DRAIN;
                end else begin
                    beat_s    = beat_r + CNTW'(1);
                    // Column wraps inside the row; the row never advances.
                    col_s     = bank_column + COLWIDTH'(1);
                    rd_o_wr_s = wr_r;
                    if (wr_r) begin
                        dqin_s = wdata_r[int'(beat_s) * DEVICE_WIDTH +: DEVICE_WIDTH];
                    end else begin
                        dqin_s = '0;
                    end
                end
            end
            DRAIN: begin
                state_s     = RESP;
                rsp_valid_s = 1'b1;
                rsp_wr_s    = wr_r;
            end
            RESP: begin
                state_s = IDLE;
                ready_s = 1'b1;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            beat_r       <= '0;
            wr_r         <= 1'b0;
            wdata_r      <= '0;
            rd_pend_r    <= 1'b0;
            rd_idx_r     <= '0;
            req_ready    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_wr       <= 1'b0;
            rsp_rdata    <= '0;
            bank_rd_o_wr <= 1'b0;
            bank_dqin    <= '0;
            bank_row     <= '0;
            bank_column  <= '0;
        end else begin
            state_r      <= state_s;
            beat_r       <= beat_s;
            wr_r         <= wr_s;
            wdata_r      <= wdata_s;
            rd_pend_r    <= rd_pend_s;
            rd_idx_r     <= rd_idx_s;
            req_ready    <= ready_s;
            rsp_valid    <= rsp_valid_s;
            rsp_wr       <= rsp_wr_s;
            rsp_rdata    <= rdata_s;
            bank_rd_o_wr <= rd_o_wr_s;
            bank_dqin    <= dqin_s;
            bank_row     <= row_s;
            bank_column  <= col_s;
        end
    end

endmodule

// File: tb/tb_bank_burst_ctrl.sv
// -----------------------------------------------------------------------------
// Self-checking bench for bank_burst_ctrl with a behavioural one-cycle-latency
// Bank and a reference memory. Accepted requests push expected Bank writes and
// responses (with their due cycle) to queues; monitors pop and compare.
// -----------------------------------------------------------------------------
module tb_bank_burst_ctrl;

    localparam int DWID = 4;
    localparam int CW   = 10;
    localparam int RW   = 5;
    localparam int BL   = 8;

    typedef struct {
        int           cyc;
        logic [RW-1:0] row;
        logic [CW-1:0] col;
        logic [DWID-1:0] d;
    } wexp_t;

    typedef struct {
        int              cyc;
        logic            wr;
        logic [DWID*BL-1:0] data;
    } rexp_t;

    logic                 clk;
    logic                 rst;
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_wr;
    logic [RW-1:0]        req_row;
    logic [CW-1:0]        req_col;
    logic [DWID*BL-1:0]   req_wdata;
    logic                 rsp_valid;
    logic                 rsp_wr;
    logic [DWID*BL-1:0]   rsp_rdata;
    logic                 bank_rd_o_wr;
    logic [DWID-1:0]      bank_dqin;
    logic [DWID-1:0]      bank_dqout;
    logic [RW-1:0]        bank_row;
    logic [CW-1:0]        bank_column;

    logic [DWID-1:0] bank_mem [32][1024];
    logic [DWID-1:0] ref_mem  [32][1024];

    wexp_t wq[$];
    rexp_t rq[$];
    int    acc_q[$];
    int    cyc;
    int    vecs;
    int    errs;
    bit    acc_flag;

    bank_burst_ctrl #(
        .DEVICE_WIDTH(DWID), .COLWIDTH(CW), .CHWIDTH(RW), .BL(BL)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_row(req_row), .req_col(req_col), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_wr(rsp_wr), .rsp_rdata(rsp_rdata),
        .bank_rd_o_wr(bank_rd_o_wr), .bank_dqin(bank_dqin), .bank_dqout(bank_dqout),
        .bank_row(bank_row), .bank_column(bank_column)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter: value seen at a negedge names the current cycle.
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural Bank: write at the edge, registered read (latency 1).
    always @(posedge clk) begin
        if (bank_rd_o_wr === 1'b1) bank_mem[bank_row][bank_column] <= bank_dqin;
        bank_dqout <= bank_mem[bank_row][bank_column];
    end

    // Acceptor: the coming edge accepts; push expectations from the bench model.
    always @(negedge clk) begin
        if (req_valid === 1'b1 && req_ready === 1'b1 && rst === 1'b0) begin
            logic [CW-1:0]      c;
            logic [DWID*BL-1:0] rd;
            acc_flag = 1'b1;
            acc_q.push_back(cyc);
            rd = '0;
            for (int k = 0; k < BL; k++) begin
                c = req_col + CW'(k);
                if (req_wr) begin
                    ref_mem[req_row][c] = req_wdata[k*DWID +: DWID];
                    wq.push_back('{cyc + 1 + k, req_row, c, req_wdata[k*DWID +: DWID]});
                end else begin
                    rd[k*DWID +: DWID] = ref_mem[req_row][c];
                end
            end
            rq.push_back('{cyc + BL + 2, req_wr, rd});
        end
    end

    // Write monitor: every Bank write must be an expected beat at its cycle.
    always @(negedge clk) begin
        if (bank_rd_o_wr === 1'b1) begin
            wexp_t e;
            vecs++;
            if (wq.size() == 0) begin
                errs++;
                $display("FAIL spurious_write cyc=%0d row=%0d col=%0d d=%h", cyc, bank_row, bank_column, bank_dqin);
            end else begin
                e = wq.pop_front();
                if ({cyc, bank_row, bank_column, bank_dqin} !== {e.cyc, e.row, e.col, e.d}) begin
                    errs++;
                    $display("FAIL write_beat got cyc=%0d row=%0d col=%0d d=%h exp cyc=%0d row=%0d col=%0d d=%h",
                             cyc, bank_row, bank_column, bank_dqin, e.cyc, e.row, e.col, e.d);
                end
            end
        end
    end

    // Response monitor.
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            rexp_t e;
            vecs++;
            if (rq.size() == 0) begin
                errs++;
                $display("FAIL spurious_rsp cyc=%0d wr=%b", cyc, rsp_wr);
            end else begin
                e = rq.pop_front();
                if (cyc !== e.cyc || rsp_wr !== e.wr || (!e.wr && rsp_rdata !== e.data)) begin
                    errs++;
                    $display("FAIL response got cyc=%0d wr=%b data=%h exp cyc=%0d wr=%b data=%h",
                             cyc, rsp_wr, rsp_rdata, e.cyc, e.wr, e.data);
                end
            end
        end
    end

    // Present a request (called #1 after an edge) and hold it until accepted.
    task automatic issue(input logic wr, input logic [RW-1:0] row, input logic [CW-1:0] col,
                         input logic [DWID*BL-1:0] data);
        int n;
        n = 0;
        acc_flag  = 1'b0;
        req_wr    = wr;
        req_row   = row;
        req_col   = col;
        req_wdata = data;
        req_valid = 1'b1;
        while (!acc_flag && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        req_valid = 1'b0;
        if (!acc_flag) begin
            vecs++;
            errs++;
            $display("FAIL issue_timeout got no acceptance exp acceptance within 50 cycles");
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((wq.size() != 0 || rq.size() != 0) && n < 100) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        if (wq.size() != 0 || rq.size() != 0) begin
            vecs++;
            errs++;
            $display("FAIL drain_timeout got pending wq=%0d rq=%0d exp 0 0", wq.size(), rq.size());
            wq.delete();
            rq.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b1; req_wr = 1'b1;
        req_row = 5'd9; req_col = 10'd33; req_wdata = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vecs++;
            if ({req_ready, rsp_valid, rsp_wr, rsp_rdata, bank_rd_o_wr, bank_dqin, bank_row, bank_column} !== '0) begin
                errs++;
                $display("FAIL reset_outputs got rdy=%b rv=%b rw=%b rd=%h wr=%b dq=%h row=%0d col=%0d exp all 0",
                         req_ready, rsp_valid, rsp_wr, rsp_rdata, bank_rd_o_wr, bank_dqin, bank_row, bank_column);
            end
        end
        rst = 1'b0;
        #1;
        vecs++;
        if (req_ready !== 1'b0) begin
            errs++;
            $display("FAIL ready_at_deassert got %b exp 0", req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        vecs++;
        if (req_ready !== 1'b1) begin
            errs++;
            $display("FAIL ready_after_reset got %b exp 1", req_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_write_read();
        issue(1'b1, 5'd3, 10'd16, 32'h76543210);
        wait_done();
        issue(1'b0, 5'd3, 10'd16, 32'h00000000);
        wait_done();
    endtask

    task automatic test_wrap();
        issue(1'b1, 5'd7, 10'd1020, 32'h9ABCDEF1);
        wait_done();
        issue(1'b0, 5'd7, 10'd1020, 32'h00000000);
        wait_done();
    endtask

    task automatic test_back_to_back();
        int base;
        int n;
        base = acc_q.size();
        n = 0;
        req_valid = 1'b1;
        while (acc_q.size() < base + 5 && n < 80) begin
            req_wr    = 1'($urandom_range(0, 1));
            req_row   = RW'($urandom_range(0, 31));
            req_col   = CW'($urandom_range(0, 1023));
            req_wdata = 32'($urandom);
            @(posedge clk);
            #1;
            n++;
        end
        req_valid = 1'b0;
        for (int i = base + 1; i < acc_q.size(); i++) begin
            vecs++;
            if (acc_q[i] - acc_q[i-1] !== BL + 3) begin
                errs++;
                $display("FAIL accept_spacing got %0d exp %0d", acc_q[i] - acc_q[i-1], BL + 3);
            end
        end
        vecs++;
        if (acc_q.size() !== base + 5) begin
            errs++;
            $display("FAIL accept_count got %0d exp %0d", acc_q.size() - base, 5);
        end
        wait_done();
    endtask

    task automatic test_reset_mid_write();
        logic [DWID-1:0] saved [3];
        for (int i = 0; i < 3; i++) saved[i] = ref_mem[2][5 + i];
        issue(1'b1, 5'd2, 10'd0, 32'hFEDCBA98);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;                 // sampled at the edge ending beat 4
        @(posedge clk);
        #1;
        rst = 1'b0;
        vecs++;
        if (wq.size() !== 3) begin
            errs++;
            $display("FAIL abort_beats got %0d pending beats exp 3", wq.size());
        end
        wq.delete();
        rq.delete();
        for (int i = 0; i < 3; i++) ref_mem[2][5 + i] = saved[i];
        @(negedge clk);
        vecs++;
        if ({bank_rd_o_wr, bank_dqin, bank_row, bank_column, rsp_valid, req_ready} !== '0) begin
            errs++;
            $display("FAIL abort_outputs got wr=%b dq=%h row=%0d col=%0d rv=%b rdy=%b exp all 0",
                     bank_rd_o_wr, bank_dqin, bank_row, bank_column, rsp_valid, req_ready);
        end
        repeat (14) @(posedge clk);  // any rsp_valid here is flagged spurious
        #1;
        issue(1'b0, 5'd2, 10'd0, 32'h00000000);
        wait_done();
    endtask

    task automatic test_idle();
        int wr_seen;
        int diffs;
        wr_seen = 0;
        diffs = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bank_rd_o_wr !== 1'b0) wr_seen++;
        end
        vecs++;
        if (wr_seen !== 0) begin
            errs++;
            $display("FAIL idle_writes got %0d exp 0", wr_seen);
        end
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 1024; c++)
                if (bank_mem[r][c] !== ref_mem[r][c]) diffs++;
        vecs++;
        if (diffs !== 0) begin
            errs++;
            $display("FAIL bank_contents got %0d differing words exp 0", diffs);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        cyc = 0; vecs = 0; errs = 0; acc_flag = 1'b0;
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 1024; c++) begin
                bank_mem[r][c] = DWID'(r * 7 + c * 3);
                ref_mem[r][c]  = DWID'(r * 7 + c * 3);
            end
        test_reset();
        test_write_read();
        test_wrap();
        test_back_to_back();
        test_reset_mid_write();
        test_idle();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/bank_burst_ctrl.md
# bank_burst_ctrl

Burst initiator for a single Bank model. It accepts one read or write request per transaction over a valid/ready handshake and converts it into BL consecutive column accesses on the Bank's row/column/rd_o_wr/dq port. For reads it collects the returned beats into one wide response word. It sits between the rank/channel command logic and one Bank instance, and is the requesting side of the Bank's storage interface.

## Interface
- DEVICE_WIDTH, 4, bits per column access; must match the attached Bank
- COLWIDTH, 10, column address width; must match the attached Bank
- CHWIDTH, 5, modeled-row address width; must match the attached Bank
- BL, 8, beats per burst; legal range 1..2**COLWIDTH

Ports:
- clk  in  1  single clock; also clocks the attached Bank
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_wr  in  1  1 = write burst, 0 = read burst
- req_row  in  CHWIDTH  target modeled row
- req_col  in  COLWIDTH  starting column
- req_wdata  in  DEVICE_WIDTH*BL  write data; beat k is at [k*DEVICE_WIDTH +: DEVICE_WIDTH]
- rsp_valid  out  1  one-cycle completion pulse
- rsp_wr  out  1  kind of the completed transaction
- rsp_rdata  out  DEVICE_WIDTH*BL  read data, packed the same way as req_wdata
- bank_rd_o_wr  out  1  to Bank rd_o_wr; 0 = read, 1 = write
- bank_dqin  out  DEVICE_WIDTH  to Bank dqin
- bank_dqout  in  DEVICE_WIDTH  from Bank dqout
- bank_row  out  CHWIDTH  to Bank row
- bank_column  out  COLWIDTH  to Bank column

## Operation
- Bank read latency is 1 cycle. Data for an address presented in cycle N is valid on bank_dqout during cycle N+1.
- FSM states: IDLE, BURST, DRAIN, RESP.
  - IDLE: req_ready=1. On the edge where req_valid && req_ready, latch req_wr, req_row, req_col and req_wdata, clear the beat counter, and go to BURST.
  - BURST: one beat per cycle, beat counter 0..BL-1. Go to DRAIN after beat BL-1.
  - DRAIN: one cycle. Captures the final read beat; no Bank access.
  - RESP: rsp_valid=1 for one cycle, then go to IDLE.
- Beat k addressing:
  - bank_row = latched row.
  - bank_column = (req_col + k) mod 2**COLWIDTH. The column wraps within the row and the row never increments.
- Write beat:
  - bank_rd_o_wr=1.
  - bank_dqin = wdata beat k.
- Read beat:
  - bank_rd_o_wr=0.
  - The bank_dqout sampled in the following cycle is stored to rsp_rdata beat k.
  - The rsp_rdata register updates in place during the burst. It is defined only while rsp_valid=1, and it holds its value otherwise.
  - Write transactions do not modify rsp_rdata.
- Bank-side outputs outside write beats:
  - bank_rd_o_wr=0 and bank_dqin=0.
  - bank_row and bank_column hold their last driven values.
  - No spurious writes are permitted.
- Handshake rules:
  - req_ready is 0 in BURST, DRAIN, RESP and while rst=1.
  - req_valid is ignored when req_ready=0.
  - Request fields are sampled only on the accepting edge. Later changes have no effect.
- rsp_wr = latched req_wr. It is valid while rsp_valid=1.

## Timing
- All outputs are registered.
- Reset values:
  - req_ready=0 while rst=1, and 1 in the first cycle after rst deasserts.
  - rsp_valid=0, rsp_wr=0, rsp_rdata=0.
  - bank_rd_o_wr=0, bank_dqin=0, bank_row=0, bank_column=0.
  - State is IDLE.
- Let request acceptance happen at the edge ending cycle A:
  - Beat k is driven during cycle A+1+k.
  - DRAIN occupies cycle A+BL+1.
  - rsp_valid=1 during cycle A+BL+2.
  - req_ready=1 again in cycle A+BL+3.
- Maximum throughput is one transaction per BL+3 cycles. With BL=8, rsp_valid is high in A+10 and req_ready is high in A+11.
- Read capture: beat k data is sampled at the edge ending cycle A+2+k. The last beat is captured at the edge ending DRAIN.
- Reset mid-transaction:
  - At the edge where rst=1 is sampled, the FSM goes to IDLE and every output takes its reset value.
  - A write beat already being driven in that cycle commits to the Bank. No later beat is issued.
  - No rsp_valid is produced for the aborted transaction.
- If req_valid=1 in the cycle rst deasserts, it is not accepted, because req_ready=0. Acceptance happens at the next edge at the earliest.

## Test plan
- Reset: hold rst for 3 cycles with req_valid=1.
  - During reset, all outputs are 0 and no Bank write occurs.
  - req_ready=1 in the first post-reset cycle.
- Write then read (BL=8, row 3, col 16):
  - Write wdata 0x76543210.
  - Bank columns 16..23 are written in cycles A+1..A+8, and rsp_valid/rsp_wr=1 appear at A+10.
  - A read of the same address returns rsp_rdata=0x76543210 with rsp_wr=0.
- Column wrap: write a burst at col 1020 (COLWIDTH=10).
  - Columns go 1020, 1021, 1022, 1023, 0, 1, 2, 3.
  - bank_row stays constant.
  - A readback returns identical data.
- Busy behavior: hold req_valid=1 continuously with changing fields.
  - Exactly one acceptance per 11 cycles.
  - Fields that change after acceptance do not alter the Bank addresses or data in flight.
- Reset mid-write: assert rst during beat 4 of a write at col 0.
  - Columns 0..4 are written and columns 5..7 keep their old contents.
  - No rsp_valid is produced.
  - A following read returns the expected mixed data.
- Idle hygiene: with no requests for 100 cycles, bank_rd_o_wr stays 0 and Bank contents are unchanged.
